riscv_core_16booth_seq_mul: RTL and testbench

- Iterative radix-16 Booth multiplier sequencer for the RISC-V M-extension MUL/MULH/MULHSU/MULHU.
- Holds one operand pair, feeds one 5-bit Booth group per cycle to a single radix-16 encoder, and accumulates the shifted partial products.
- Sits between the execute-stage issue logic (valid/ready in) and writeback (valid/ready out).
- Trades latency for area against the fully parallel tree.

---
 rtl/riscv_core_16booth_seq_mul_pkg.sv | 25 ++
 rtl/riscv_core_16booth_seq_mul_if.sv | 27 ++
 rtl/riscv_core_16booth_seq_mul_encoder.sv | 48 ++++
 rtl/riscv_core_16booth_seq_mul.sv | 118 +++++++++++
 tb/tb_riscv_core_16booth_seq_mul.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_core_16booth_seq_mul_pkg.sv
// Shared types and sizing helpers for the iterative radix-16 Booth multiplier.
package riscv_core_mul_pkg;

    typedef enum logic [1:0] {
        MUL    = 2'b00,
        MULH   = 2'b01,
        MULHSU = 2'b10,
        MULHU  = 2'b11
    } mul_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } mul_state_e;

    function automatic int MUL_NUM_GROUPS(input int xlen);
        return (xlen + 4) / 4;
    endfunction

    function automatic int MUL_ACC_W(input int xlen);
        return 2 * xlen + 4;
    endfunction

endpackage

// File: rtl/riscv_core_16booth_seq_mul_if.sv
// Issue/writeback handshake bundle of the sequential multiplier.
interface riscv_core_16booth_seq_mul_if #(
    parameter int XLEN = 64
);
    logic            i_mul_valid;
    logic            o_mul_ready;
    logic [1:0]      i_mul_op;
    logic [XLEN-1:0] i_mul_rs1;
    logic [XLEN-1:0] i_mul_rs2;
    logic            i_mul_flush;
    logic            o_mul_valid;
    logic            i_mul_ready;
    logic [XLEN-1:0] o_mul_result;
    logic            o_mul_busy;

    modport slave (
        input  i_mul_valid, i_mul_op, i_mul_rs1, i_mul_rs2,
        input  i_mul_flush, i_mul_ready,
        output o_mul_ready, o_mul_valid, o_mul_result, o_mul_busy
    );

    modport master (
        output i_mul_valid, i_mul_op, i_mul_rs1, i_mul_rs2,
        output i_mul_flush, i_mul_ready,
        input  o_mul_ready, o_mul_valid, o_mul_result, o_mul_busy
    );
endinterface

// File: rtl/riscv_core_16booth_seq_mul_encoder.sv
// Radix-16 Booth encoder: pp = digit(sel) * muld, digit in -8..8.
module riscv_core_16booth_encoder #(
    parameter int XLEN = 64
) (
    input  logic [XLEN:0]   muld_i,
    input  logic [4:0]      sel_i,
    output logic [XLEN+3:0] pp_o
);
    localparam int W = XLEN + 4;

    logic [3:0]   low;
    logic [3:0]   mag;
    logic         neg;
    logic [W-1:0] m1, m2, m3, m4, m5, m6, m7, m8;
    logic [W-1:0] mag_pp;

    // low part 4s3+2s2+s1+s0 is 0..8; a set s4 subtracts it from 8
    assign low = {1'b0, sel_i[3:1]} + {3'b000, sel_i[0]};
    assign mag = sel_i[4] ? 4'd8 - low : low;
    assign neg = sel_i[4] & (low != 4'd8);

    assign m1 = {{3{muld_i[XLEN]}}, muld_i};
    assign m2 = m1 << 1;
    assign m3 = m1 + m2;
    assign m4 = m1 << 2;
    assign m5 = m4 + m1;
    assign m6 = m3 << 1;
    assign m8 = m1 << 3;
    assign m7 = m8 - m1;

    always_comb begin
        mag_pp = '0;
        case (mag)
            4'd1:    mag_pp = m1;
            4'd2:    mag_pp = m2;
            4'd3:    mag_pp = m3;
            4'd4:    mag_pp = m4;
            4'd5:    mag_pp = m5;
            4'd6:    mag_pp = m6;
            4'd7:    mag_pp = m7;
            4'd8:    mag_pp = m8;
            default: mag_pp = '0;
        endcase
    end

    assign pp_o = neg ? -mag_pp : mag_pp;

endmodule

// File: rtl/riscv_core_16booth_seq_mul.sv
// Iterative radix-16 Booth multiplier for MUL/MULH/MULHSU/MULHU.
// Define RISCV_CORE_MUL_EARLY_TERM_EN to stop once remaining groups are all zero.
module riscv_core_16booth_seq_mul
    import riscv_core_mul_pkg::*;
#(
    parameter int XLEN = 64
) (
    input logic i_clk,
    input logic i_rst,
    riscv_core_16booth_seq_mul_if.slave bus
);
    localparam int NG    = MUL_NUM_GROUPS(XLEN);
    localparam int ACC_W = MUL_ACC_W(XLEN);
    localparam int PP_W  = XLEN + 4;
    localparam int M_W   = XLEN + 5;
    localparam int CNT_W = $clog2(NG);
    localparam int SH_W  = $clog2(ACC_W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NG - 1);

    mul_state_e       state_q, state_d;
    mul_op_e          op_q;
    mul_op_e          op_in;
    logic [XLEN:0]    md_q;
    logic [M_W-1:0]   m_q;
    logic [CNT_W-1:0] cnt_q;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             res_valid_q;
    logic [XLEN-1:0]  result_q;

    logic [XLEN:0]    rs1_x, rs2_x;
    logic             rdy, accept, last_grp;
    logic [4:0]       sel;
    logic [PP_W-1:0]  pp;
    logic [SH_W-1:0]  sh;
    logic [ACC_W-1:0] addend;

    assign op_in = mul_op_e'(bus.i_mul_op);
    assign rs1_x = {(op_in != MULHU) & bus.i_mul_rs1[XLEN-1],
                    bus.i_mul_rs1};
    assign rs2_x = {((op_in == MUL) | (op_in == MULH)) & bus.i_mul_rs2[XLEN-1],
                    bus.i_mul_rs2};

    assign rdy    = (state_q == IDLE) & ~i_rst;
    assign accept = bus.i_mul_valid & rdy & ~bus.i_mul_flush;

    assign sh  = SH_W'({cnt_q, 2'b00});
    assign sel = m_q[sh +: 5];

    riscv_core_16booth_encoder #(
        .XLEN (XLEN)
    ) u_enc (
        .muld_i (md_q),
        .sel_i  (sel),
        .pp_o   (pp)
    );

    assign addend = {{(ACC_W - PP_W){pp[PP_W-1]}}, pp} << sh;
    assign acc_d  = acc_q + addend;

`ifdef RISCV_CORE_MUL_EARLY_TERM_EN
    logic [SH_W-1:0]        sh_nxt;
    logic signed [M_W-1:0]  rest;

    // uniform upper bits encode only zero digits from here on
    assign sh_nxt   = sh + SH_W'(4);
    assign rest     = $signed(m_q) >>> sh_nxt;
    assign last_grp = (cnt_q == LAST) | (rest == '0) | (rest == '1);
`else
    assign last_grp = (cnt_q == LAST);
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = CALC;
            CALC:    if (last_grp) state_d = DONE;
            DONE:    if (bus.i_mul_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (bus.i_mul_flush) state_d = IDLE;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            op_q        <= MUL;
            md_q        <= '0;
            m_q         <= '0;
            cnt_q       <= '0;
            acc_q       <= '0;
            res_valid_q <= 1'b0;
            result_q    <= '0;
        end else begin
            state_q     <= state_d;
            res_valid_q <= (state_d == DONE);
            if (accept) begin
                md_q  <= rs1_x;
                m_q   <= {{3{rs2_x[XLEN]}}, rs2_x, 1'b0};
                op_q  <= op_in;
                cnt_q <= '0;
                acc_q <= '0;
            end else if (state_q == CALC) begin
                acc_q <= acc_d;
                cnt_q <= cnt_q + CNT_W'(1);
                if (last_grp && !bus.i_mul_flush) begin
                    result_q <= (op_q == MUL) ? acc_d[XLEN-1:0]
                                              : acc_d[2*XLEN-1:XLEN];
                end
            end
        end
    end

    assign bus.o_mul_ready  = rdy;
    assign bus.o_mul_valid  = res_valid_q;
    assign bus.o_mul_result = result_q;
    assign bus.o_mul_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_riscv_core_16booth_seq_mul.sv
// Scoreboard bench for the sequential radix-16 Booth multiplier.
module tb_riscv_core_16booth_seq_mul;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    bit   bp_en;

    logic [63:0] exp_q[$];

    riscv_core_16booth_seq_mul_if #(.XLEN(64)) bus ();

    riscv_core_16booth_seq_mul #(.XLEN(64)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [1:0] op,
                                            input logic [63:0] a,
                                            input logic [63:0] b);
        logic signed [129:0] sa, sb, p;
        sa = (op == 2'b11) ? $signed({66'b0, a}) : $signed({{66{a[63]}}, a});
        sb = op[1] ? $signed({66'b0, b}) : $signed({{66{b[63]}}, b});
        p  = sa * sb;
        return (op == 2'b00) ? p[63:0] : p[127:64];
    endfunction

    function automatic logic [63:0] rnd_opnd();
        case ($urandom_range(0, 7))
            0:       return 64'h0;
            1:       return 64'hFFFF_FFFF_FFFF_FFFF;
            2:       return 64'h8000_0000_0000_0000;
            3:       return 64'h7FFF_FFFF_FFFF_FFFF;
            4:       return 64'(int'($urandom_range(0, 40)) - 20);
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Result monitor: a transfer completes at the next rising edge
    always @(negedge clk) begin
        if (!rst && bus.o_mul_valid && bus.i_mul_ready) begin
            if (exp_q.size() == 0) begin
                chk("sb_underflow", bus.o_mul_result, 64'hX);
            end else begin
                chk("result", bus.o_mul_result, exp_q.pop_front());
            end
        end
    end

    always @(posedge clk) begin
        if (bp_en) begin
            #1;
            bus.i_mul_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic issue(input logic [1:0] op, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] exp,
                         input bit push);
        int n;
        n = 0;
        bus.i_mul_valid = 1'b1;
        bus.i_mul_op    = op;
        bus.i_mul_rs1   = a;
        bus.i_mul_rs2   = b;
        @(negedge clk);
        while (!bus.o_mul_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("accept", bus.o_mul_ready, 1);
        if (push) exp_q.push_back(exp);
        @(posedge clk);
        #1;
        bus.i_mul_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!bus.o_mul_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.o_mul_busy) && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain", 64'(exp_q.size()), 0);
    endtask

    initial begin
        int n;
        int seen;
        logic [1:0]  op;
        logic [63:0] a, b;
        checks = 0;
        errors = 0;
        bp_en  = 1'b0;
        rst    = 1'b1;
        bus.i_mul_valid = 1'b0;
        bus.i_mul_op    = 2'b00;
        bus.i_mul_rs1   = '0;
        bus.i_mul_rs2   = '0;
        bus.i_mul_flush = 1'b0;
        bus.i_mul_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", bus.o_mul_valid, 0);
        chk("rst_result", bus.o_mul_result, 0);
        chk("rst_busy", bus.o_mul_busy, 0);
        chk("rst_ready", bus.o_mul_ready, 0);
        rst = 1'b0;
        #1;
        chk("idle_ready", bus.o_mul_ready, 1);

        // MULHU all-ones; valid 18 cycles after the accept edge
        issue(2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
              64'hFFFF_FFFF_FFFF_FFFE, 1);
        wait_valid(n);
        chk("lat_mulhu", 64'(n + 1), 18);
        wait_idle();

        issue(2'b01, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
              64'h4000_0000_0000_0000, 1);
        issue(2'b00, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
              64'h0, 1);
        issue(2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
              64'hFFFF_FFFF_FFFF_FFFF, 1);
        issue(2'b00, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7,
              64'hFFFF_FFFF_FFFF_FFEB, 1);
        wait_idle();

        // Backpressure in DONE
        bus.i_mul_ready = 1'b0;
        issue(2'b00, 64'd1000, 64'd3, 64'd3000, 1);
        wait_valid(n);
        repeat (5) begin
            chk("bp_valid", bus.o_mul_valid, 1);
            chk("bp_result", bus.o_mul_result, 64'd3000);
            chk("bp_ready", bus.o_mul_ready, 0);
            @(posedge clk);
            #1;
        end
        bus.i_mul_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_rel_ready", bus.o_mul_ready, 1);
        chk("bp_rel_valid", bus.o_mul_valid, 0);
        issue(2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1, 1);
        wait_idle();

        // Flush in the 7th CALC cycle
        issue(2'b00, 64'd5, 64'd5, 64'd0, 0);
        repeat (6) @(posedge clk);
        #1;
        bus.i_mul_flush = 1'b1;
        @(posedge clk);
        #1;
        bus.i_mul_flush = 1'b0;
        chk("flush_busy", bus.o_mul_busy, 0);
        chk("flush_ready", bus.o_mul_ready, 1);
        seen = 0;
        repeat (20) begin
            if (bus.o_mul_valid) seen++;
            @(posedge clk);
            #1;
        end
        chk("flush_novalid", 64'(seen), 0);

        // Flush in DONE drops the result
        bus.i_mul_ready = 1'b0;
        issue(2'b00, 64'd9, 64'd9, 64'd0, 0);
        wait_valid(n);
        bus.i_mul_flush = 1'b1;
        @(posedge clk);
        #1;
        bus.i_mul_flush = 1'b0;
        chk("flushdone_valid", bus.o_mul_valid, 0);
        chk("flushdone_busy", bus.o_mul_busy, 0);
        bus.i_mul_ready = 1'b1;

        // Flush together with a request in IDLE
        bus.i_mul_valid = 1'b1;
        bus.i_mul_flush = 1'b1;
        @(posedge clk);
        #1;
        bus.i_mul_valid = 1'b0;
        bus.i_mul_flush = 1'b0;
        chk("flushidle_busy", bus.o_mul_busy, 0);

        issue(2'b00, 64'd123, 64'd456, 64'd56088, 1);
        wait_idle();

        // Reset in the middle of CALC
        issue(2'b00, 64'd77, 64'd77, 64'd0, 0);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rstmid_valid", bus.o_mul_valid, 0);
        chk("rstmid_result", bus.o_mul_result, 0);
        chk("rstmid_busy", bus.o_mul_busy, 0);
        chk("rstmid_ready", bus.o_mul_ready, 0);
        rst = 1'b0;
        #1;
        chk("rstmid_ready_rel", bus.o_mul_ready, 1);

`ifdef RISCV_CORE_MUL_EARLY_TERM_EN
        issue(2'b00, 64'd7, 64'd5, 64'd35, 1);
        wait_valid(n);
        chk("lat_et_35", 64'(n + 1), 2);
        wait_idle();
        issue(2'b00, 64'd7, 64'hFFFF_FFFF_FFFF_FFFF,
              64'hFFFF_FFFF_FFFF_FFF9, 1);
        wait_valid(n);
        chk("lat_et_neg", 64'(n + 1), 2);
        wait_idle();
`endif

        // Random operations against the reference product
        bp_en = 1'b1;
        for (int i = 0; i < 200; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = rnd_opnd();
            b  = rnd_opnd();
            issue(op, a, b, ref_mul(op, a, b), 1);
        end
        bp_en = 1'b0;
        @(posedge clk);
        #2;
        bus.i_mul_ready = 1'b1;
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
